dwt_coef_writer: RTL and testbench

//  Downstream of the D4 MAC stage. Takes packed {L,H} coefficient pairs, reorders them into Mallat subband layout and writes them byte-serially into the frame buffer.

---
 rtl/dwt_pkg.sv | 34 +++
 rtl/dwt_coef_writer_if.sv | 31 +++
 rtl/dwt_pair_fifo.sv | 54 +++++
 rtl/dwt_coef_writer.sv | 122 ++++++++++++
 tb/tb_dwt_coef_writer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dwt_pkg.sv
// rtl/dwt_pkg.sv - shared constants, drain state encoding and pair-entry layout for the DWT coefficient writer
package dwt_pkg;

    localparam logic PASS_ROW = 1'b0;
    localparam logic PASS_COL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_L = 2'd1,
        ST_WR_H = 2'd2
    } drain_state_e;

    // Entry packs upward from bit 0: H byte, L byte, k, line, pass
    localparam int H_LSB = 0;
    localparam int L_LSB = 8;
    localparam int K_LSB = 16;

    function automatic int addr_width(input int width);
        return $clog2(width);
    endfunction

    function automatic int line_lsb(input int aw);
        return K_LSB + aw;
    endfunction

    function automatic int pass_pos(input int aw);
        return K_LSB + 2 * aw;
    endfunction

    function automatic int entry_bits(input int aw);
        return K_LSB + 2 * aw + 1;
    endfunction

endpackage

// File: rtl/dwt_coef_writer_if.sv
// rtl/dwt_coef_writer_if.sv - coefficient input, frame-buffer write and status signals of the writer
interface dwt_coef_writer_if #(parameter int WIDTH = 256);
    import dwt_pkg::*;

    localparam int AW = addr_width(WIDTH);

    logic            i_valid;
    logic [15:0]     i_pixel;
    logic [AW-1:0]   i_pixel_pointer;
    logic [AW-1:0]   i_row_column_pointer;
    logic            i_pass;
    logic            o_ready;
    logic            o_busy;
    logic            mem_we;
    logic [2*AW-1:0] mem_addr;
    logic [7:0]      mem_wdata;
    logic            o_line_done;
    logic            o_pass_done;
    logic            o_overflow;

    modport master (
        output i_valid, i_pixel, i_pixel_pointer, i_row_column_pointer, i_pass,
        input  o_ready, o_busy, mem_we, mem_addr, mem_wdata, o_line_done, o_pass_done, o_overflow
    );

    modport slave (
        input  i_valid, i_pixel, i_pixel_pointer, i_row_column_pointer, i_pass,
        output o_ready, o_busy, mem_we, mem_addr, mem_wdata, o_line_done, o_pass_done, o_overflow
    );

endinterface

// File: rtl/dwt_pair_fifo.sv
// rtl/dwt_pair_fifo.sv - synchronous FIFO, one push and one pop per cycle, a push into a full FIFO is taken when a pop frees a slot
module dwt_pair_fifo #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dwt_coef_writer.sv
// rtl/dwt_coef_writer.sv - buffers {L,H} pairs and writes them byte-serially into the frame buffer in Mallat layout
module dwt_coef_writer
    import dwt_pkg::*;
#(
    parameter int WIDTH      = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int PIPE_SLACK = 4
) (
    input logic              clk,
    input logic              rst,
    dwt_coef_writer_if.slave bus
);
    localparam int AW       = addr_width(WIDTH);
    localparam int HALF     = WIDTH / 2;
    localparam int EW       = entry_bits(AW);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int LINE_LSB = line_lsb(AW);
    localparam int PASS_POS = pass_pos(AW);

    drain_state_e    state, state_n;
    logic [EW-1:0]   push_entry;
    logic [EW-1:0]   head;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop;
    logic [7:0]      l_byte, h_byte;
    logic [AW-1:0]   head_k, head_line;
    logic [2*AW-1:0] l_addr, h_addr, cur_addr, last_addr;
    logic [7:0]      cur_data, last_data;
    logic            we, line_done;
    logic [AW-1:0]   line_cnt;
    logic            overflow;

    assign push_entry = {bus.i_pass, bus.i_row_column_pointer, bus.i_pixel_pointer, bus.i_pixel};
    assign push       = bus.i_valid && (!full || pop);

    dwt_pair_fifo #(.DATA_W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign h_byte    = head[H_LSB +: 8];
    assign l_byte    = head[L_LSB +: 8];
    assign head_k    = head[K_LSB +: AW];
    assign head_line = head[LINE_LSB +: AW];

    // k < HALF, so adding HALF never carries out of the AW-bit field
    always_comb begin
        if (head[PASS_POS] == PASS_COL) begin
            l_addr = {head_k, head_line};
            h_addr = {head_k + AW'(HALF), head_line};
        end else begin
            l_addr = {head_line, head_k};
            h_addr = {head_line, head_k + AW'(HALF)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        we        = 1'b0;
        pop       = 1'b0;
        line_done = 1'b0;
        cur_addr  = l_addr;
        cur_data  = l_byte;
        case (state)
            ST_IDLE: begin
                if (!empty) state_n = ST_WR_L;
            end
            ST_WR_L: begin
                we      = 1'b1;
                state_n = ST_WR_H;
            end
            ST_WR_H: begin
                we        = 1'b1;
                pop       = 1'b1;
                cur_addr  = h_addr;
                cur_data  = h_byte;
                line_done = (head_k == AW'(HALF - 1));
                // count is pre-pop; a pair pushed this cycle is picked up via IDLE
                state_n   = (count > CW'(1)) ? ST_WR_L : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt  <= '0;
            overflow  <= 1'b0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            if (line_done)                   line_cnt <= line_cnt + AW'(1);
            if (bus.i_valid && full && !pop) overflow <= 1'b1;
            if (we) begin
                last_addr <= cur_addr;
                last_data <= cur_data;
            end
        end
    end

    assign bus.o_ready     = (FIFO_DEPTH - int'(count)) > PIPE_SLACK;
    assign bus.o_busy      = !empty || (state != ST_IDLE);
    assign bus.mem_we      = we;
    assign bus.mem_addr    = we ? cur_addr : last_addr;
    assign bus.mem_wdata   = we ? cur_data : last_data;
    assign bus.o_line_done = line_done;
    assign bus.o_pass_done = line_done && (line_cnt == AW'(WIDTH - 1));
    assign bus.o_overflow  = overflow;

endmodule

// File: tb/tb_dwt_coef_writer.sv
// tb/tb_dwt_coef_writer.sv - directed bench for dwt_coef_writer with a cycle-schedule reference model
module tb_dwt_coef_writer;
    import dwt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dwt_coef_writer_if #(.WIDTH(256)) b0();
    dwt_coef_writer_if #(.WIDTH(8))   b1();

    dwt_coef_writer #(.WIDTH(256), .FIFO_DEPTH(8), .PIPE_SLACK(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
    dwt_coef_writer #(.WIDTH(8),   .FIFO_DEPTH(8), .PIPE_SLACK(4)) u1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct { int d; int cyc; int addr; int data; bit ld; bit pd; } wr_t;
    typedef struct { int d; int pt; int ht; } ent_t;

    wr_t  wq[$];
    ent_t pend[$];
    int   wdim[2] = '{256, 8};
    int   last_h[2], lines[2], ovf_from[2], last_addr[2], last_data[2];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   checking = 0;
    bit   ff_on = 0;
    int   wr_cnt[2] = '{0, 0};
    int   ld_cnt = 0;
    int   pd_cnt = 0;
    int   hits[64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: an entry's L byte goes out at max(push+2, previous H+1), its H byte one cycle later
    function automatic int model_count(input int d, input int t);
        int n = 0;
        foreach (pend[i]) if (pend[i].d == d && pend[i].pt < t && pend[i].ht >= t) n++;
        return n;
    endfunction

    function automatic bit model_pops(input int d, input int t);
        bit p = 0;
        foreach (pend[i]) if (pend[i].d == d && pend[i].ht == t) p = 1;
        return p;
    endfunction

    task automatic model_reset();
        pend.delete();
        wq.delete();
        for (int d = 0; d < 2; d++) begin
            last_h[d] = -100; lines[d] = 0; ovf_from[d] = -1; last_addr[d] = 0; last_data[d] = 0;
        end
    endtask

    task automatic model_push(input int d, input int t, input logic [15:0] pix, input int k, input int line, input bit pass);
        int w, half, la, ha, lt;
        bit ld, pd;
        w = wdim[d]; half = w / 2;
        if (model_count(d, t) < 8 || model_pops(d, t)) begin
            lt = (t + 2 > last_h[d] + 1) ? t + 2 : last_h[d] + 1;
            last_h[d] = lt + 1;
            pend.push_back('{d, t, lt + 1});
            if (!pass) begin la = line * w + k;  ha = line * w + half + k; end
            else       begin la = k * w + line;  ha = (k + half) * w + line; end
            ld = (k == half - 1); pd = 0;
            if (ld) begin
                lines[d]++;
                if (lines[d] == w) begin pd = 1; lines[d] = 0; end
            end
            wq.push_back('{d, lt, la, int'(pix[15:8]), 1'b0, 1'b0});
            wq.push_back('{d, lt + 1, ha, int'(pix[7:0]), ld, pd});
        end else if (ovf_from[d] < 0) begin
            ovf_from[d] = t + 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && checking) begin
            for (int d = 0; d < 2; d++) begin
                int idx, we_v, ad_v, da_v, ld_v, pd_v, cnt;
                idx = -1;
                for (int i = 0; i < wq.size(); i++) if (idx < 0 && wq[i].d == d) idx = i;
                we_v = (d == 0) ? int'(b0.mem_we)      : int'(b1.mem_we);
                ad_v = (d == 0) ? int'(b0.mem_addr)    : int'(b1.mem_addr);
                da_v = (d == 0) ? int'(b0.mem_wdata)   : int'(b1.mem_wdata);
                ld_v = (d == 0) ? int'(b0.o_line_done) : int'(b1.o_line_done);
                pd_v = (d == 0) ? int'(b0.o_pass_done) : int'(b1.o_pass_done);
                if (idx >= 0 && wq[idx].cyc == cyc) begin
                    chk("we", we_v, 1);
                    chk("addr", ad_v, wq[idx].addr);
                    chk("wdata", da_v, wq[idx].data);
                    chk("line_done", ld_v, int'(wq[idx].ld));
                    chk("pass_done", pd_v, int'(wq[idx].pd));
                    last_addr[d] = wq[idx].addr;
                    last_data[d] = wq[idx].data;
                    wq.delete(idx);
                end else begin
                    chk("we_idle", we_v, 0);
                    chk("line_done_idle", ld_v, 0);
                    chk("pass_done_idle", pd_v, 0);
                    chk("addr_hold", ad_v, last_addr[d]);
                    chk("wdata_hold", da_v, last_data[d]);
                end
                cnt = model_count(d, cyc);
                chk("ready", (d == 0) ? int'(b0.o_ready) : int'(b1.o_ready), int'((8 - cnt) > 4));
                chk("busy", (d == 0) ? int'(b0.o_busy) : int'(b1.o_busy), int'(cnt > 0));
                chk("overflow", (d == 0) ? int'(b0.o_overflow) : int'(b1.o_overflow),
                    int'(ovf_from[d] >= 0 && cyc >= ovf_from[d]));
                wr_cnt[d] += we_v;
                if (d == 1 && ff_on) begin
                    ld_cnt += ld_v;
                    pd_cnt += pd_v;
                    if (we_v != 0) hits[ad_v]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        b0.i_valid = 1'b0;
        b1.i_valid = 1'b0;
    endtask

    task automatic drive(input int d, input logic [15:0] pix, input int k, input int line, input bit pass);
        if (d == 0) begin
            b0.i_valid = 1'b1; b0.i_pixel = pix; b0.i_pixel_pointer = 8'(k);
            b0.i_row_column_pointer = 8'(line); b0.i_pass = pass;
        end else begin
            b1.i_valid = 1'b1; b1.i_pixel = pix; b1.i_pixel_pointer = 3'(k);
            b1.i_row_column_pointer = 3'(line); b1.i_pass = pass;
        end
        model_push(d, cyc, pix, k, line, pass);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((b0.o_busy || b1.o_busy) && n < 300) begin step(); n++; end
        chk("drain_timeout", int'(n < 300), 1);
    endtask

    initial begin
        int i, j, first_low, w0, once;
        logic [15:0] p;
        bit r[$];
        bit launch;

        b0.i_valid = 0; b0.i_pixel = '0; b0.i_pixel_pointer = '0; b0.i_row_column_pointer = '0; b0.i_pass = 0;
        b1.i_valid = 0; b1.i_pixel = '0; b1.i_pixel_pointer = '0; b1.i_row_column_pointer = '0; b1.i_pass = 0;
        foreach (hits[a]) hits[a] = 0;
        model_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checking = 1;
        chk("rst_ready", int'(b0.o_ready), 1);
        chk("rst_busy", int'(b0.o_busy), 0);
        chk("rst_we", int'(b0.mem_we), 0);
        chk("rst_addr", int'(b0.mem_addr), 0);
        chk("rst_ovf", int'(b1.o_overflow), 0);
        step();

        // single pair, row pass
        drive(0, 16'hA17F, 5, 3, PASS_ROW);
        step(); step();
        chk("row_l_we", int'(b0.mem_we), 1);
        chk("row_l_addr", int'(b0.mem_addr), 773);
        chk("row_l_data", int'(b0.mem_wdata), 'hA1);
        step();
        chk("row_h_addr", int'(b0.mem_addr), 901);
        chk("row_h_data", int'(b0.mem_wdata), 'h7F);
        wait_drain();

        // single pair, column pass
        drive(0, 16'h1020, 1, 2, PASS_COL);
        step(); step();
        chk("col_l_addr", int'(b0.mem_addr), 258);
        chk("col_l_data", int'(b0.mem_wdata), 'h10);
        step();
        chk("col_h_addr", int'(b0.mem_addr), 33026);
        chk("col_h_data", int'(b0.mem_wdata), 'h20);
        wait_drain();

        // feeder honouring o_ready with a 4-cycle lag
        w0 = wr_cnt[0]; i = 0; j = 0; first_low = -1;
        while (i < 128 && j < 2000) begin
            r.push_back(b0.o_ready);
            if (!b0.o_ready && first_low < 0) first_low = j;
            launch = 1'b1;
            if (j >= 4) launch = r[j - 4];
            if (launch) begin
                p = {8'(i * 3 + 1), 8'(i * 7 + 2)};
                drive(0, p, i % 128, 5, PASS_ROW);
                i++;
            end
            step(); j++;
        end
        chk("feeder_pairs", i, 128);
        chk("ready_fall_cycle", first_low, 5);
        wait_drain();
        chk("feeder_writes", wr_cnt[0] - w0, 256);
        chk("feeder_no_ovf", int'(b0.o_overflow), 0);

        // full frame, row pass, WIDTH=8
        ff_on = 1; i = 0; j = 0;
        while (i < 32 && j < 1000) begin
            if (b1.o_ready) begin
                p = {8'(i + 8'h40), 8'(i + 8'h80)};
                drive(1, p, i % 4, i / 4, PASS_ROW);
                i++;
            end
            step(); j++;
        end
        chk("frame_pairs", i, 32);
        wait_drain();
        ff_on = 0;
        once = 0;
        foreach (hits[a]) if (hits[a] == 1) once++;
        chk("frame_line_done", ld_cnt, 8);
        chk("frame_pass_done", pd_cnt, 1);
        chk("frame_addr_once", once, 64);

        // overflow: 16 unthrottled pairs, the 15th lands on a full FIFO
        w0 = wr_cnt[0];
        for (int n = 0; n < 16; n++) begin
            p = {8'(n + 8'h30), 8'(n + 8'h60)};
            drive(0, p, n, 10, PASS_ROW);
            step();
        end
        wait_drain();
        chk("ovf_sticky", int'(b0.o_overflow), 1);
        chk("ovf_writes", wr_cnt[0] - w0, 30);

        // reset with three pairs buffered
        for (int n = 0; n < 3; n++) begin
            drive(0, 16'h5500 | 16'(n), 20 + n, 11, PASS_ROW);
            step();
        end
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        chk("rst_mid_we", int'(b0.mem_we), 0);
        chk("rst_mid_busy", int'(b0.o_busy), 0);
        chk("rst_mid_ready", int'(b0.o_ready), 1);
        chk("rst_mid_ovf", int'(b0.o_overflow), 0);
        w0 = wr_cnt[0];
        repeat (20) step();
        chk("rst_no_stale", wr_cnt[0] - w0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
